// File: rtl/sensor_conditioner.sv
// sensor_conditioner: synchronises and debounces the four car detectors and
// the pedestrian button. Outputs are clean car levels, sticky per-lane
// requests and a one-cycle pedestrian press pulse.
//
// Optional feature macro: SENSOR_STUCK_DETECT_EN
//   Defined   -> per-lane stuck-high detection. A stuck lane masks its car
//                level and holds its request clear.
//   Undefined -> no stuck counters are built, and stuck reads 4'b0000.
//
// Channel map for the internal vectors: bits 3:0 carry lanes 1..4, and
// bit 4 carries the pedestrian button.
module sensor_conditioner #(
  parameter int DB_CYCLES    = 4,
  parameter int STUCK_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] car_raw,
  input  logic       ped_raw,
  input  logic [3:0] car_clr,
  output logic [3:0] car,
  output logic [3:0] car_req,
  output logic       ped,
  output logic [3:0] stuck
);

  localparam logic [3:0] DB_TC = 4'(DB_CYCLES);

  // Catch illegal parameter overrides when the design is elaborated.
  if (DB_CYCLES < 1 || DB_CYCLES > 15) begin : g_bad_db
    $error("sensor_conditioner: DB_CYCLES out of range 1..15");
  end
  if (STUCK_CYCLES < 1 || STUCK_CYCLES > 255) begin : g_bad_stuck
    $error("sensor_conditioner: STUCK_CYCLES out of range 1..255");
  end

  logic [4:0] s1;
  logic [4:0] s2;
  logic [4:0] db;
  logic [4:0] db_nxt;
  logic [3:0] cnt     [5];
  logic [3:0] cnt_nxt [5];
  logic       ped_prev;
  logic [3:0] car_prev;
  logic [3:0] car_req_nxt;
  logic [3:0] stuck_q;

  // Two-flop synchroniser on all five raw inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {ped_raw, car_raw};
      s2 <= s1;
    end
  end

  // Debounce step: count cycles of disagreement. The level toggles on the
  // cycle the count would reach DB_CYCLES, and any agreement restarts the run.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      db_nxt[i]  = db[i];
      cnt_nxt[i] = '0;
      if (s2[i] != db[i]) begin
        if (cnt[i] + 4'd1 == DB_TC) begin
          db_nxt[i]  = ~db[i];
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      db <= db_nxt;
      for (int i = 0; i < 5; i++) cnt[i] <= cnt_nxt[i];
    end
  end

`ifdef SENSOR_STUCK_DETECT_EN
  logic [7:0] stk_cnt [4];

  // Saturating high-time counter per lane. The flag sets on the edge where
  // the count reaches STUCK_CYCLES and stays set until the lane's level falls.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (reset || !db[i]) begin
        stk_cnt[i] <= '0;
        stuck_q[i] <= 1'b0;
      end else begin
        if (stk_cnt[i] != 8'hFF) stk_cnt[i] <= stk_cnt[i] + 8'd1;
        if (stk_cnt[i] >= 8'(STUCK_CYCLES - 1)) stuck_q[i] <= 1'b1;
      end
    end
  end
`else
  assign stuck_q = 4'b0000;
`endif

  // A stuck lane is presented to the controller as empty.
  assign car   = db[3:0] & ~stuck_q;
  assign stuck = stuck_q;

  // A new arrival beats a clear landing on the same cycle, so no car is lost.
  // A stuck lane never holds a request.
  always_comb begin
    car_req_nxt = ((car & ~car_prev) | (car_req & ~car_clr)) & ~stuck_q;
  end

  // Edge-detect history, request bits and the pedestrian pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      car_prev <= '0;
      car_req  <= '0;
      ped_prev <= 1'b0;
      ped      <= 1'b0;
    end else begin
      car_prev <= car;
      car_req  <= car_req_nxt;
      ped_prev <= db[4];
      ped      <= db[4] & ~ped_prev;
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner in its default build (DB_CYCLES=4,
// stuck detection disabled). Inputs change 1 ns after a rising edge, and
// outputs are sampled at the same point.
module tb_sensor_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] car_raw;
  logic       ped_raw;
  logic [3:0] car_clr;
  logic [3:0] car;
  logic [3:0] car_req;
  logic       ped;
  logic [3:0] stuck;

  int checks = 0;
  int errors = 0;

  sensor_conditioner dut (
    .clock   (clock),
    .reset   (reset),
    .car_raw (car_raw),
    .ped_raw (ped_raw),
    .car_clr (car_clr),
    .car     (car),
    .car_req (car_req),
    .ped     (ped),
    .stuck   (stuck)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    car_raw = 4'b1111;
    ped_raw = 1'b1;
    car_clr = 4'b0000;

    // Reset is held for one edge while all raw inputs are high.
    step(1);
    check("reset_car",     car,           4'b0000);
    check("reset_car_req", car_req,       4'b0000);
    check("reset_ped",     {3'b000, ped}, 4'b0000);
    check("reset_stuck",   stuck,         4'b0000);

    // Release reset. All lanes and the button rise together, so each output
    // should appear on its nominal edge.
    reset = 1'b0;
    step(5);
    check("all_car_edge5", car,           4'b0000);
    check("all_ped_edge5", {3'b000, ped}, 4'b0000);
    step(1);
    check("all_car_edge6", car,           4'b1111);
    check("all_req_edge6", car_req,       4'b0000);
    check("all_ped_edge6", {3'b000, ped}, 4'b0000);
    step(1);
    check("all_ped_edge7", {3'b000, ped}, 4'b0001);
    check("all_req_edge7", car_req,       4'b1111);
    step(1);
    check("all_ped_edge8", {3'b000, ped}, 4'b0000);
    check("stuck_default", stuck,         4'b0000);

    // Holding the button must not produce further pulses.
    for (int k = 0; k < 12; k++) begin
      step(1);
      check("ped_hold", {3'b000, ped}, 4'b0000);
    end

    // Clear every request.
    car_clr = 4'b1111;
    step(1);
    check("clr_all", car_req, 4'b0000);
    car_clr = 4'b0000;

    // Release everything: car levels fall, and neither the release nor the
    // falling levels produce a pulse or a request.
    car_raw = 4'b0000;
    ped_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("ped_release", {3'b000, ped}, 4'b0000);
      check("req_release", car_req,       4'b0000);
    end
    check("car_released", car, 4'b0000);

    // A 3-cycle glitch on lane 1 is rejected.
    car_raw[0] = 1'b1;
    step(3);
    car_raw[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      check("glitch_car", car, 4'b0000);
    end

    // A sustained press on lane 1: the level rises on edge 6 and the
    // request follows on edge 7.
    car_raw[0] = 1'b1;
    step(5);
    check("l1_car_edge5", car,     4'b0000);
    step(1);
    check("l1_car_edge6", car,     4'b0001);
    check("l1_req_edge6", car_req, 4'b0000);
    step(1);
    check("l1_req_edge7", car_req, 4'b0001);

    // Race on lane 3: the clear arrives in the same cycle that car[2] rises,
    // and the set must win.
    car_raw[2] = 1'b1;
    step(6);
    check("l3_car_edge6", car, 4'b0101);
    car_clr = 4'b0100;
    step(1);
    check("race_set_wins", car_req, 4'b0101);
    car_clr = 4'b0000;
    step(1);
    check("race_hold", car_req, 4'b0101);
    car_clr = 4'b0100;
    step(1);
    check("clr_lane3", car_req, 4'b0001);
    car_clr = 4'b0000;
    step(1);
    check("clr_lane3_stays", car_req, 4'b0001);

    // A clear on a bit that is already clear has no effect.
    car_clr = 4'b0010;
    step(1);
    check("clr_idle_bit", car_req, 4'b0001);
    car_clr = 4'b0000;

    // A reset in the middle of a debounce run on lane 2 discards the partial
    // count, so a full run is needed after reset drops.
    car_raw[1] = 1'b1;
    step(4);
    check("mid_db_before", car, 4'b0101);
    reset = 1'b1;
    step(1);
    check("mid_db_reset_car", car,     4'b0000);
    check("mid_db_reset_req", car_req, 4'b0000);
    reset = 1'b0;
    step(5);
    check("mid_db_edge5", car, 4'b0000);
    step(1);
    check("mid_db_edge6", car, 4'b0111);
    step(1);
    check("mid_db_req7", car_req, 4'b0111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
